// File: rtl/uart_tx_arbiter.sv
// Two-requester, message-granular round-robin front end for a shared UART transmit controller.
// Drives the controller's Start/Empty handshake and inserts an idle gap after every message.
module uart_tx_arbiter #(
  parameter int unsigned GAP_TICKS = 2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       TX_clock_enable,
  input  logic       Req0_valid,
  input  logic [7:0] Req0_data,
  input  logic       Req0_last,
  output logic       Req0_ready,
  input  logic       Req1_valid,
  input  logic [7:0] Req1_data,
  input  logic       Req1_last,
  output logic       Req1_ready,
  output logic       TXC_start,
  output logic [7:0] TXC_data,
  input  logic       TXC_empty,
  output logic [1:0] Grant,
  output logic       Busy,
  output logic [7:0] Byte_count,
  output logic       Msg_done
);

  localparam logic [2:0] S_ARB       = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_START     = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_GAP       = 3'd4;

  localparam int unsigned GAP_W = (GAP_TICKS < 1) ? 1 : $clog2(GAP_TICKS + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_TICKS == 0) ? 0 : GAP_TICKS - 1);

  logic [2:0]       state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             rr_q, rr_d;          // index of the requester served last
  logic             start_q, start_d;
  logic [7:0]       data_q, data_d;
  logic             last_q, last_d;
  logic [7:0]       count_q, count_d;
  logic             done_q, done_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic       sel_valid;
  logic [7:0] sel_data;
  logic       sel_last;

  // Only the granted requester's byte can ever reach the controller.
  assign sel_valid = grant_q[1] ? Req1_valid : (grant_q[0] & Req0_valid);
  assign sel_data  = grant_q[1] ? Req1_data  : Req0_data;
  assign sel_last  = grant_q[1] ? Req1_last  : Req0_last;

  assign Req0_ready = (state_q == S_FETCH) && grant_q[0];
  assign Req1_ready = (state_q == S_FETCH) && grant_q[1];

  always_comb begin
    // NOTE: every _d starts from its held value so no path through the case infers a latch.
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    start_d = start_q;
    data_d  = data_q;
    last_d  = last_q;
    count_d = count_q;
    done_d  = 1'b0;
    gap_d   = gap_q;

    case (state_q)
      S_ARB: begin
        if (Req0_valid || Req1_valid) begin
          if (Req0_valid && Req1_valid) begin
            grant_d = rr_q ? 2'b01 : 2'b10;
          end else begin
            grant_d = Req0_valid ? 2'b01 : 2'b10;
          end
          count_d = 8'd0;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        if (sel_valid) begin
          data_d  = sel_data;
          last_d  = sel_last;
          if (count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
          end
          start_d = 1'b1;
          state_d = S_START;
        end
      end

      S_START: begin
        // Start stays asserted until the controller takes it on a baud tick.
        if (TX_clock_enable && TXC_empty) begin
          start_d = 1'b0;
          state_d = S_WAIT_DONE;
        end
      end

      S_WAIT_DONE: begin
        if (TXC_empty) begin
          if (last_q) begin
            done_d  = 1'b1;
            grant_d = 2'b00;
            rr_d    = grant_q[1];
            gap_d   = '0;
            state_d = (GAP_TICKS == 0) ? S_ARB : S_GAP;
          end else begin
            state_d = S_FETCH;
          end
        end
      end

      S_GAP: begin
        if (TX_clock_enable) begin
          if (gap_q == GAP_LAST) begin
            state_d = S_ARB;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
      end

      default: begin
        state_d = S_ARB;
        grant_d = 2'b00;
        start_d = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_ARB;
      grant_q <= 2'b00;
      rr_q    <= 1'b1;
      start_q <= 1'b0;
      data_q  <= 8'h00;
      last_q  <= 1'b0;
      count_q <= 8'd0;
      done_q  <= 1'b0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      start_q <= start_d;
      data_q  <= data_d;
      last_q  <= last_d;
      count_q <= count_d;
      done_q  <= done_d;
      gap_q   <= gap_d;
    end
  end

  assign TXC_start  = start_q;
  assign TXC_data   = data_q;
  assign Grant      = grant_q;
  assign Busy       = (state_q != S_ARB);
  assign Byte_count = count_q;
  assign Msg_done   = done_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: two queued requesters plus a behavioural
// 10-bit UART transmit controller that records every bit it puts on the line.
module tb_uart_tx_arbiter;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       TX_clock_enable = 1'b0;
  logic       Req0_valid = 1'b0;
  logic [7:0] Req0_data = 8'h00;
  logic       Req0_last = 1'b0;
  logic       Req0_ready;
  logic       Req1_valid = 1'b0;
  logic [7:0] Req1_data = 8'h00;
  logic       Req1_last = 1'b0;
  logic       Req1_ready;
  logic       TXC_start;
  logic [7:0] TXC_data;
  logic       TXC_empty;
  logic [1:0] Grant;
  logic       Busy;
  logic [7:0] Byte_count;
  logic       Msg_done;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.GAP_TICKS(2)) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .TX_clock_enable(TX_clock_enable),
    .Req0_valid     (Req0_valid),
    .Req0_data      (Req0_data),
    .Req0_last      (Req0_last),
    .Req0_ready     (Req0_ready),
    .Req1_valid     (Req1_valid),
    .Req1_data      (Req1_data),
    .Req1_last      (Req1_last),
    .Req1_ready     (Req1_ready),
    .TXC_start      (TXC_start),
    .TXC_data       (TXC_data),
    .TXC_empty      (TXC_empty),
    .Grant          (Grant),
    .Busy           (Busy),
    .Byte_count     (Byte_count),
    .Msg_done       (Msg_done)
  );

  always #5 Clock = ~Clock;

  // Baud tick every 4 clocks unless held off.
  int   div = 0;
  logic en_block = 1'b0;
  always @(negedge Clock) begin
    div = (div + 1) % 4;
    TX_clock_enable = (div == 0) && !en_block;
  end

  // Transmit controller model: start bit on the accepting tick, 8 data bits
  // LSB first, Empty rises together with the stop bit.
  logic        empty_m;
  logic [8:0]  sh_m;
  int unsigned bits_left;
  logic        bitlog[$];

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      empty_m   <= 1'b1;
      sh_m      <= '1;
      bits_left <= 0;
    end else if (TX_clock_enable) begin
      if (bits_left == 0) begin
        if (TXC_start && empty_m) begin
          sh_m      <= {1'b1, TXC_data};
          bits_left <= 9;
          empty_m   <= 1'b0;
          bitlog.push_back(1'b0);
        end
      end else begin
        sh_m      <= {1'b1, sh_m[8:1]};
        bits_left <= bits_left - 1;
        bitlog.push_back(sh_m[0]);
        if (bits_left == 1) empty_m <= 1'b1;
      end
    end
  end
  assign TXC_empty = empty_m;

  // Requester sources: the initial block only appends; the read index advances
  // on each handshake and skips everything pending when Reset hits.
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  int rd0 = 0;
  int rd1 = 0;

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rd0 <= q0.size();
      rd1 <= q1.size();
    end else begin
      if (Req0_valid && Req0_ready) rd0 <= rd0 + 1;
      if (Req1_valid && Req1_ready) rd1 <= rd1 + 1;
    end
  end

  always @(negedge Clock) begin
    Req0_valid = rd0 < q0.size();
    {Req0_last, Req0_data} = (rd0 < q0.size()) ? q0[rd0] : 9'h000;
    Req1_valid = rd1 < q1.size();
    {Req1_last, Req1_data} = (rd1 < q1.size()) ? q1[rd1] : 9'h000;
  end

  int unsigned gap_ticks = 0;
  int unsigned r0_ready_cycles = 0;
  always @(posedge Clock) begin
    if (TX_clock_enable && Busy && (Grant == 2'b00)) gap_ticks <= gap_ticks + 1;
    if (Req0_ready) r0_ready_cycles <= r0_ready_cycles + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] frame_byte(input int b);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = bitlog[b + 1 + i];
    return v;
  endfunction

  task automatic wait_grant();
    for (int n = 0; n < 2000 && Grant == 2'b00; n++) @(negedge Clock);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!Msg_done && n < 3000) begin
      @(negedge Clock);
      n++;
    end
    check(tag, Msg_done, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (Busy && n < 2000) begin
      @(negedge Clock);
      n++;
    end
    check(tag, Busy, 1'b0);
  endtask

  task automatic wait_start(input logic lvl, input string tag);
    int n = 0;
    while (TXC_start !== lvl && n < 2000) begin
      @(negedge Clock);
      n++;
    end
    check(tag, TXC_start, lvl);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base_bits;
    int base_gap;
    int base_r0;
    int good;
    int n;
    logic [9:0] fr;
    logic [7:0] exp3[6];

    // 1: reset values
    repeat (2) @(negedge Clock);
    check("t1_start", TXC_start, 1'b0);
    check("t1_data", TXC_data, 8'h00);
    check("t1_grant", Grant, 2'b00);
    check("t1_busy", Busy, 1'b0);
    check("t1_count", Byte_count, 8'd0);
    check("t1_done", Msg_done, 1'b0);
    check("t1_ready0", Req0_ready, 1'b0);
    check("t1_ready1", Req1_ready, 1'b0);
    Reset = 1'b0;
    repeat (2) @(negedge Clock);

    // 2: single one-byte message from Req0
    base_bits = bitlog.size();
    base_r0 = r0_ready_cycles;
    q0.push_back({1'b1, 8'h55});
    wait_grant();
    check("t2_grant", Grant, 2'b01);
    wait_start(1'b1, "t2_start_high");
    check("t2_txc_data", TXC_data, 8'h55);
    n = 0;
    do begin
      @(posedge Clock);
      n++;
    end while (!(TX_clock_enable && TXC_empty) && n < 200);
    @(negedge Clock);
    check("t2_start_dropped", TXC_start, 1'b0);
    check("t2_ready_cycles", r0_ready_cycles - base_r0, 1);
    wait_done("t2_msg_done");
    check("t2_empty_at_done", TXC_empty, 1'b1);
    check("t2_count", Byte_count, 8'd1);
    check("t2_grant_released", Grant, 2'b00);
    for (int i = 0; i < 10; i++) fr[i] = bitlog[base_bits + i];
    check("t2_line_bits", fr, 10'b1010101010);
    @(negedge Clock);
    check("t2_done_pulse", Msg_done, 1'b0);

    // Reset so the round-robin pointer prefers Req0 again.
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);

    // 3: contention, then gap, then second message
    base_bits = bitlog.size();
    base_gap = gap_ticks;
    exp3 = '{8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2, 8'hB3};
    q0.push_back({1'b0, 8'hA1});
    q0.push_back({1'b0, 8'hA2});
    q0.push_back({1'b1, 8'hA3});
    q1.push_back({1'b0, 8'hB1});
    q1.push_back({1'b0, 8'hB2});
    q1.push_back({1'b1, 8'hB3});
    wait_grant();
    check("t3_grant_a", Grant, 2'b01);
    wait_done("t3_done_a");
    check("t3_count_a", Byte_count, 8'd3);
    wait_grant();
    check("t3_grant_b", Grant, 2'b10);
    check("t3_gap_ticks", gap_ticks - base_gap, 2);
    wait_done("t3_done_b");
    check("t3_count_b", Byte_count, 8'd3);
    for (int i = 0; i < 6; i++) check($sformatf("t3_order_%0d", i), frame_byte(base_bits + 10 * i), exp3[i]);
    q0.push_back({1'b1, 8'hC0});
    q1.push_back({1'b1, 8'hC1});
    wait_grant();
    check("t3_rr_req0", Grant, 2'b01);
    wait_done("t3_done_c0");
    wait_grant();
    check("t3_rr_req1", Grant, 2'b10);
    wait_done("t3_done_c1");

    // 4: mid-message stall keeps the lock
    q1.push_back({1'b0, 8'h10});
    wait_grant();
    check("t4_grant", Grant, 2'b10);
    n = 0;
    while (rd1 != q1.size() && n < 2000) begin
      @(negedge Clock);
      n++;
    end
    q0.push_back({1'b1, 8'h77});
    @(negedge Clock);
    good = 0;
    repeat (50) begin
      @(negedge Clock);
      if (Grant == 2'b10 && !Req0_ready && Req0_valid) good++;
    end
    check("t4_stall_hold", good, 50);
    q1.push_back({1'b1, 8'h20});
    wait_done("t4_done");
    check("t4_count", Byte_count, 8'd2);
    wait_grant();
    check("t4_req0_next", Grant, 2'b01);
    wait_done("t4_done_req0");

    // 5: enable starvation while Start is pending
    wait_idle("t5_idle");
    en_block = 1'b1;
    q1.push_back({1'b1, 8'h3C});
    wait_start(1'b1, "t5_start_high");
    good = 0;
    repeat (100) begin
      @(negedge Clock);
      if (TXC_start && TXC_data == 8'h3C && Busy) good++;
    end
    check("t5_start_stable", good, 100);
    en_block = 1'b0;
    n = 0;
    do begin
      @(posedge Clock);
      n++;
    end while (!TX_clock_enable && n < 50);
    @(negedge Clock);
    check("t5_accept_first_tick", TXC_start, 1'b0);
    wait_done("t5_done");
    check("t5_count", Byte_count, 8'd1);

    // 6: asynchronous reset while waiting on a byte, then clean recovery
    wait_idle("t6_idle");
    q0.push_back({1'b0, 8'hD1});
    q0.push_back({1'b0, 8'hD2});
    q0.push_back({1'b1, 8'hD3});
    wait_grant();
    check("t6_grant", Grant, 2'b01);
    wait_start(1'b1, "t6_start_high");
    wait_start(1'b0, "t6_accepted");
    repeat (6) @(negedge Clock);
    check("t6_busy_before", Busy, 1'b1);
    check("t6_sending_before", TXC_empty, 1'b0);
    #2 Reset = 1'b1;
    #1;
    check("t6_start", TXC_start, 1'b0);
    check("t6_data", TXC_data, 8'h00);
    check("t6_grant_rst", Grant, 2'b00);
    check("t6_busy", Busy, 1'b0);
    check("t6_count_rst", Byte_count, 8'd0);
    check("t6_done", Msg_done, 1'b0);
    check("t6_ready0", Req0_ready, 1'b0);
    check("t6_ready1", Req1_ready, 1'b0);
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    base_bits = bitlog.size();
    q1.push_back({1'b1, 8'hA5});
    wait_grant();
    check("t6_grant_new", Grant, 2'b10);
    wait_done("t6_done_new");
    check("t6_count_new", Byte_count, 8'd1);
    check("t6_byte_new", frame_byte(base_bits), 8'hA5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmit controller between two byte-stream requesters.
- Arbitrates round-robin at message granularity: a granted requester keeps the transmitter until its byte flagged "last" has fully left the line.
- Sequences each byte through the transmitter's Start/Empty handshake and inserts a configurable idle gap between messages.
- Sits between client logic (message generators) and the transmit controller; shares that controller's TX_clock_enable.

Parameters:
GAP_TICKS, 2, number of TX_clock_enable ticks of idle line inserted after each message; 0 = no gap.

Ports:
Clock  input  1  system clock, all logic rising-edge.
Reset  input  1  asynchronous, active-high reset.
TX_clock_enable  input  1  baud tick shared with transmit controller.
Req0_valid  input  1  requester 0 byte available.
Req0_data  input  8  requester 0 byte.
Req0_last  input  1  byte is final byte of requester 0 message.
Req0_ready  output  1  requester 0 byte accepted this cycle.
Req1_valid / Req1_data / Req1_last / Req1_ready  same as requester 0.
TXC_start  output  1  Start to transmit controller.
TXC_data  output  8  TX_data to transmit controller.
TXC_empty  input  1  Empty from transmit controller.
Grant  output  2  one-hot owner of transmitter; 2'b00 when none.
Busy  output  1  high whenever state is not S_ARB.
Byte_count  output  8  bytes accepted in current or last message, saturates at 255.
Msg_done  output  1  one-cycle pulse when a message's last byte has finished.

Behaviour:
- Reset values: TXC_start=0, TXC_data=8'h00, Grant=2'b00, Busy=0, Byte_count=0, Msg_done=0, rr pointer prefers Req0, state S_ARB.
- Reset mid-operation aborts the message; no partial-message recovery.
- States S_ARB, S_FETCH, S_START, S_WAIT_DONE, S_GAP. Transitions are evaluated every Clock; only S_START and S_GAP qualify on TX_clock_enable.
- S_ARB:
  - If exactly one valid: grant it.
  - If both valid: grant the requester opposite the last-served one; the pointer prefers Req0 after reset.
  - On grant: Grant latched, Byte_count<=0, go S_FETCH.
  - Valid arriving while not in S_ARB waits.
- S_FETCH:
  - Reqk_ready is combinational: (state==S_FETCH)&&Grant[k]; the other ready is 0.
  - On valid&&ready: TXC_data<=data, last_flag<=last, Byte_count+1 (saturating), TXC_start<=1, go S_START.
  - Valid low: wait, grant retained (message lock, no timeout).
- S_START:
  - TXC_start and TXC_data held stable.
  - Acceptance edge is the first edge with TX_clock_enable=1 and TXC_empty=1. At that edge TXC_start<=0, go S_WAIT_DONE; the transmit controller drops Empty on the same edge.
  - TXC_start is never dropped before acceptance, regardless of how long TX_clock_enable stays low.
- S_WAIT_DONE:
  - Wait for TXC_empty=1 (set by the controller with its stop bit).
  - If last_flag: Msg_done pulses one cycle, Grant<=0, rr pointer<=served requester, go S_GAP (or S_ARB if GAP_TICKS=0).
  - Otherwise go S_FETCH.
- S_GAP:
  - Counts TX_clock_enable ticks; after GAP_TICKS ticks go S_ARB.
  - Gap counter width is $clog2(GAP_TICKS+1), min 1.
- Byte_count holds its value after Msg_done until the next grant.
- Minimum per-byte spacing is set by the transmit controller: 10 enable ticks plus ≤1 tick of acceptance wait.
- Never more than one outstanding Start; never a byte from the non-granted requester on TXC_data.

Test Plan:
1. Reset: assert Reset mid-cycle -> immediately TXC_start=0, Grant=00, Busy=0, Byte_count=0, Msg_done=0; Req0_ready=Req1_ready=0.
2. Single message, TX_clock_enable every 4 Clocks: Req0 sends 8'h55 with last=1.
   - Grant=01, Req0_ready one cycle, TXC_data=55, TXC_start high until first tick with TXC_empty=1, then low.
   - UART line shows 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop).
   - Msg_done pulses when Empty rises; Byte_count=1; Grant=00.
3. Contention, GAP_TICKS=2: both requesters valid in the same cycle, Req0 with A1,A2,A3 and Req1 with B1,B2,B3.
   - Serial order A1,A2,A3, then exactly 2 idle ticks, then B1,B2,B3; no interleaving.
   - Both valid again: Req0 granted.
4. Mid-message stall: Req1 sends 8'h10 (last=0), then holds valid low 50 Clocks while Req0_valid=1.
   - Grant stays 10 and Req0_ready stays 0.
   - Req1 then sends 8'h20 last=1; Byte_count=2; then Req0 granted.
5. Enable starvation: hold TX_clock_enable low 100 Clocks while in S_START -> TXC_start and TXC_data stable the whole time; acceptance on the first enable tick.
6. Reset during S_WAIT_DONE of a 3-byte message -> outputs at reset values. After release, a new Req1 1-byte message 8'hA5 completes normally with Byte_count=1.
